// File: rtl/axon_spike_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axon_spike_decoder: double-buffered axon spike bitmap, served lowest-first |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module axon_spike_decoder #(
  parameter int NUM_AXONS = 256,
  localparam int AW = $clog2(NUM_AXONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          spike_in_valid,
  input  logic [AW-1:0] spike_in_axon,
  input  logic          read_spike,
  output logic          decoder_empty,
  output logic [AW-1:0] axon_number_out,
  output logic          axon_number_valid,
  output logic          tick_overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENCODE  = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [NUM_AXONS-1:0] C_ONE = {{(NUM_AXONS-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [NUM_AXONS-1:0] r_cur_map;
  logic [NUM_AXONS-1:0] r_nxt_map;
  logic [AW-1:0]        r_sel;
  logic                 r_stale;
  logic                 w_axon_ok;
  logic [AW-1:0]        w_lowest;
  logic [NUM_AXONS-1:0] w_wr_mask;
  logic [NUM_AXONS-1:0] w_clr_mask;

  generate
    if (NUM_AXONS == (1 << AW)) begin : g_full_range
      assign w_axon_ok = 1'b1;
    end else begin : g_partial_range
      assign w_axon_ok = ({1'b0, spike_in_axon} < (AW+1)'(NUM_AXONS));
    end
  endgenerate

  // Lowest set index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_lowest = '0;
    for (int i = NUM_AXONS - 1; i >= 0; i--) begin
      if (r_cur_map[i]) w_lowest = AW'(i);
    end
  end

  assign w_wr_mask = (spike_in_valid && w_axon_ok) ? (C_ONE << spike_in_axon) : '0;
  // r_stale marks a sel taken from a map that a tick has since replaced.
  assign w_clr_mask = (r_state == S_PRESENT && !r_stale) ? (C_ONE << r_sel) : '0;
  assign decoder_empty = ~|r_cur_map;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= S_IDLE;
      r_cur_map         <= '0;
      r_nxt_map         <= '0;
      r_sel             <= '0;
      r_stale           <= 1'b0;
      axon_number_out   <= '0;
      axon_number_valid <= 1'b0;
      tick_overrun      <= 1'b0;
    end else begin
      tick_overrun      <= tick && |(r_cur_map & ~w_clr_mask);
      axon_number_valid <= 1'b0;

      if (tick) begin
        r_cur_map <= r_nxt_map;
        r_nxt_map <= w_wr_mask;
      end else begin
        r_cur_map <= r_cur_map & ~w_clr_mask;
        r_nxt_map <= r_nxt_map | w_wr_mask;
      end

      case (r_state)
        S_IDLE: begin
          if (read_spike && !decoder_empty) r_state <= S_ENCODE;
        end
        S_ENCODE: begin
          if (decoder_empty) begin
            r_state <= S_IDLE;
          end else begin
            r_sel   <= w_lowest;
            r_stale <= tick;
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          axon_number_out   <= r_sel;
          axon_number_valid <= 1'b1;
          r_stale           <= 1'b0;
          r_state           <= S_RELEASE;
        end
        default: begin
          if (!read_spike) r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axon_spike_decoder.sv
`default_nettype none
// Testbench for axon_spike_decoder: directed scenarios plus randomized
// spike sets checked against an ascending-order bitmap model.
module tb_axon_spike_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       spike_in_valid;
  logic [7:0] spike_in_axon;
  logic       read_spike;
  logic       decoder_empty;
  logic [7:0] axon_number_out;
  logic       axon_number_valid;
  logic       tick_overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  axon_spike_decoder #(.NUM_AXONS(256)) dut (
    .clk               (clk),
    .rst               (rst),
    .tick              (tick),
    .spike_in_valid    (spike_in_valid),
    .spike_in_axon     (spike_in_axon),
    .read_spike        (read_spike),
    .decoder_empty     (decoder_empty),
    .axon_number_out   (axon_number_out),
    .axon_number_valid (axon_number_valid),
    .tick_overrun      (tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_spike(input int a);
    spike_in_valid = 1'b1;
    spike_in_axon  = 8'(a);
    step();
    spike_in_valid = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // One request: returns whether a valid appeared, its latency in cycles and the axon.
  task automatic pop(output bit seen, output int lat, output logic [7:0] ax);
    seen = 1'b0; lat = 0; ax = '0;
    read_spike = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (axon_number_valid === 1'b1 && !seen) begin
        seen = 1'b1; lat = k; ax = axon_number_out; read_spike = 1'b0;
      end
    end
    read_spike = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    int nv = 0;
    rst = 1'b1; tick = 1'b0; spike_in_valid = 1'b0; spike_in_axon = '0; read_spike = 1'b0;
    step(); step();
    n_cmp++;
    if (decoder_empty !== 1'b1 || axon_number_valid !== 1'b0 || axon_number_out !== 8'd0 || tick_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: empty=%b valid=%b out=%0d ovr=%b, required 1 0 0 0",
               decoder_empty, axon_number_valid, axon_number_out, tick_overrun);
    end
    rst = 1'b0;
    read_spike = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (axon_number_valid !== 1'b0) nv++;
    end
    read_spike = 1'b0;
    step(); step();
    n_cmp++;
    if (nv != 0 || decoder_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_read: valid pulses=%0d empty=%b, required 0 and 1", nv, decoder_empty);
    end
  endtask

  task automatic test_basic_order();
    bit s; int l; logic [7:0] a;
    write_spike(5); write_spike(200); write_spike(5);
    do_tick();
    n_cmp++;
    if (decoder_empty !== 1'b0) begin
      n_fail++; $display("FAIL basic_loaded: empty=%b, required 0", decoder_empty);
    end
    pop(s, l, a);
    n_cmp++;
    if (!s || l != 3 || a !== 8'd5) begin
      n_fail++; $display("FAIL basic_first: seen=%0d lat=%0d axon=%0d, required 1 3 5", s, l, a);
    end
    pop(s, l, a);
    n_cmp++;
    if (!s || l != 3 || a !== 8'd200) begin
      n_fail++; $display("FAIL basic_second: seen=%0d lat=%0d axon=%0d, required 1 3 200", s, l, a);
    end
    n_cmp++;
    if (decoder_empty !== 1'b1) begin
      n_fail++; $display("FAIL basic_drained: empty=%b, required 1", decoder_empty);
    end
    pop(s, l, a);
    n_cmp++;
    if (s) begin
      n_fail++; $display("FAIL basic_third: valid seen with axon=%0d, required no valid", a);
    end
    n_cmp++;
    if (axon_number_out !== 8'd200) begin
      n_fail++; $display("FAIL out_hold: out=%0d, required 200", axon_number_out);
    end
  endtask

  task automatic test_held_request();
    int nv = 0; logic [7:0] a = '0; bit s; int l;
    write_spike(2); write_spike(1);
    do_tick();
    read_spike = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (axon_number_valid === 1'b1) begin nv++; a = axon_number_out; end
    end
    read_spike = 1'b0;
    step(); step();
    n_cmp++;
    if (nv != 1 || a !== 8'd1 || decoder_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL held_request: pops=%0d axon=%0d empty=%b, required 1 1 0", nv, a, decoder_empty);
    end
    pop(s, l, a);
    n_cmp++;
    if (!s || a !== 8'd2) begin
      n_fail++; $display("FAIL held_remaining: seen=%0d axon=%0d, required 1 2", s, a);
    end
  endtask

  task automatic test_same_cycle_write();
    bit s; int l; logic [7:0] a;
    tick = 1'b1; spike_in_valid = 1'b1; spike_in_axon = 8'd7;
    step();
    tick = 1'b0; spike_in_valid = 1'b0;
    n_cmp++;
    if (decoder_empty !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_early: empty=%b, required 1", decoder_empty);
    end
    do_tick();
    pop(s, l, a);
    n_cmp++;
    if (!s || a !== 8'd7) begin
      n_fail++; $display("FAIL same_cycle_late: seen=%0d axon=%0d, required 1 7", s, a);
    end
  endtask

  task automatic test_overrun();
    bit s; int l; logic [7:0] a;
    write_spike(4); write_spike(3);
    do_tick();
    pop(s, l, a);
    n_cmp++;
    if (a !== 8'd3) begin
      n_fail++; $display("FAIL overrun_serve: axon=%0d, required 3", a);
    end
    do_tick();
    n_cmp++;
    if (tick_overrun !== 1'b1 || decoder_empty !== 1'b1) begin
      n_fail++; $display("FAIL overrun_pulse: ovr=%b empty=%b, required 1 1", tick_overrun, decoder_empty);
    end
    step();
    n_cmp++;
    if (tick_overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_width: ovr=%b, required 0", tick_overrun);
    end
  endtask

  // Tick lands k cycles after the request (k=2 is PRESENT, k=1 is ENCODE).
  task automatic test_tick_in_flight(input int k, input int ax, input bit exp_ovr);
    bit s; int l; logic [7:0] a;
    bit ovr_seen = 1'b0;
    write_spike(ax);
    do_tick();
    write_spike(ax);
    read_spike = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      if (c == k + 1) tick = 1'b1;
      step();
      tick = 1'b0;
      if (tick_overrun === 1'b1) ovr_seen = 1'b1;
    end
    n_cmp++;
    if (axon_number_valid !== 1'b1 || axon_number_out !== 8'(ax)) begin
      n_fail++;
      $display("FAIL tick_flight%0d_serve: valid=%b out=%0d, required 1 %0d", k, axon_number_valid, axon_number_out, ax);
    end
    read_spike = 1'b0;
    step();
    if (tick_overrun === 1'b1) ovr_seen = 1'b1;
    step();
    n_cmp++;
    if (decoder_empty !== 1'b0 || ovr_seen !== exp_ovr) begin
      n_fail++;
      $display("FAIL tick_flight%0d_survive: empty=%b ovr=%b, required 0 %b", k, decoder_empty, ovr_seen, exp_ovr);
    end
    pop(s, l, a);
    n_cmp++;
    if (!s || a !== 8'(ax) || decoder_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_flight%0d_new: seen=%0d axon=%0d empty=%b, required 1 %0d 1", k, s, a, decoder_empty, ax);
    end
  endtask

  task automatic test_mid_reset();
    write_spike(12);
    do_tick();
    read_spike = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; read_spike = 1'b0;
    n_cmp++;
    if (axon_number_valid !== 1'b0 || decoder_empty !== 1'b1 || axon_number_out !== 8'd0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b empty=%b out=%0d, required 0 1 0", axon_number_valid, decoder_empty, axon_number_out);
    end
    step();
    n_cmp++;
    if (axon_number_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_late: valid=%b, required 0", axon_number_valid);
    end
  endtask

  // Model: a set of axons written this tick, served in ascending index order.
  task automatic test_random();
    bit mdl [256];
    bit s; int l; logic [7:0] a;
    int n, exp;
    for (int r = 0; r < 20; r++) begin
      foreach (mdl[i]) mdl[i] = 1'b0;
      n = $urandom_range(0, 10);
      for (int j = 0; j < n; j++) begin
        int ax = $urandom_range(0, 255);
        if ($urandom_range(0, 3) == 0 && j > 0) ax = (ax % 4) + 250;
        mdl[ax] = 1'b1;
        write_spike(ax);
      end
      do_tick();
      n_cmp++;
      if (tick_overrun !== 1'b0) begin
        n_fail++; $display("FAIL rand_ovr r=%0d: ovr=%b, required 0", r, tick_overrun);
      end
      forever begin
        exp = -1;
        for (int i = 255; i >= 0; i--) if (mdl[i]) exp = i;
        n_cmp++;
        if (decoder_empty !== (exp < 0)) begin
          n_fail++; $display("FAIL rand_empty r=%0d: empty=%b, required %b", r, decoder_empty, exp < 0);
        end
        if (exp < 0) break;
        pop(s, l, a);
        n_cmp++;
        if (!s || l != 3 || a !== 8'(exp)) begin
          n_fail++;
          $display("FAIL rand_pop r=%0d: seen=%0d lat=%0d axon=%0d, required 1 3 %0d", r, s, l, a, exp);
          break;
        end
        mdl[exp] = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_held_request();
    test_same_cycle_write();
    test_overrun();
    test_tick_in_flight(2, 9, 1'b0);
    test_tick_in_flight(1, 11, 1'b1);
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
